// File: rtl/cpu_mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package cpu_mem_arb_pkg;

  // Arbiter FSM encoding: one request phase and one response phase per channel.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_REQ  = 3'd1,
    I_RESP = 3'd2,
    D_REQ  = 3'd3,
    D_RESP = 3'd4
  } arb_state_e;

  // Consecutive data grants tolerated while a fetch waits (legal range 1-15).
  localparam int unsigned MAX_DATA_STREAK_DEF = 4;

  // Width of the streak register; wide enough for the largest legal limit.
  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/arb_perf_counter.sv
// 32-bit event counter that wraps modulo 2^32; cleared by active-low sync reset.
module arb_perf_counter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Count one event per cycle where inc_i is high; wraps naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 32'd0;
    end else if (inc_i) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the fetch channel and the load/store channel.
// Data has priority, but a fetch is forced once MAX_DATA_STREAK data grants
// have gone by while it waited. Stores are posted (no response phase).
//
// Handshakes: every channel uses valid/ready; a transfer happens on a rising
// clock edge where both valid and ready are 1. Valid must not wait for ready.
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEF,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction-fetch channel
  input  logic [ADDR_W-1:0]     PC,
  input  logic                  Inst_Req_Valid,
  output logic                  Inst_Req_Ready,
  output logic [DATA_W-1:0]     Instruction,
  output logic                  Inst_Valid,
  input  logic                  Inst_Ready,
  // Data channel
  input  logic [ADDR_W-1:0]     Address,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [DATA_W-1:0]     Write_data,
  input  logic [DATA_W/8-1:0]   Write_strb,
  output logic                  Mem_Req_Ready,
  output logic [DATA_W-1:0]     Read_data,
  output logic                  Read_data_Valid,
  input  logic                  Read_data_Ready,
  // Downstream memory port
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wstrb,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic                  mem_rdata_ready,
  // Performance counters
  output logic [31:0]           perf_inst_grant,
  output logic [31:0]           perf_data_grant,
  output logic [31:0]           perf_conflict
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                dreq;
  logic                inst_inc, data_inc, conflict_inc;

  // State and streak registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Next-state, streak update and all channel outputs from the current owner.
  always_comb begin
    state_d         = state_q;
    streak_d        = streak_q;
    dreq            = MemRead | MemWrite;
    Inst_Req_Ready  = 1'b0;
    Instruction     = '0;
    Inst_Valid      = 1'b0;
    Mem_Req_Ready   = 1'b0;
    Read_data       = '0;
    Read_data_Valid = 1'b0;
    mem_req_valid   = 1'b0;
    mem_req_addr    = '0;
    mem_req_wen     = 1'b0;
    mem_req_wdata   = '0;
    mem_req_wstrb   = '0;
    mem_rdata_ready = 1'b0;
    inst_inc        = 1'b0;
    data_inc        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dreq && Inst_Req_Valid && (streak_q == STREAK_MAX)) begin
          state_d = I_REQ;
        end else if (dreq) begin
          state_d = D_REQ;
        end else if (Inst_Req_Valid) begin
          state_d = I_REQ;
        end
      end
      I_REQ: begin
        mem_req_valid  = Inst_Req_Valid;
        mem_req_addr   = PC;
        Inst_Req_Ready = mem_req_ready;
        if (Inst_Req_Valid && mem_req_ready) begin
          state_d  = I_RESP;
          inst_inc = 1'b1;
          streak_d = '0;
        end else if (!Inst_Req_Valid) begin
          state_d = IDLE;
        end
      end
      I_RESP: begin
        Inst_Valid      = mem_rdata_valid;
        Instruction     = mem_rdata_valid ? mem_rdata : '0;
        mem_rdata_ready = Inst_Ready;
        if (mem_rdata_valid && Inst_Ready) begin
          state_d = IDLE;
        end
      end
      D_REQ: begin
        mem_req_valid = dreq;
        mem_req_addr  = Address;
        mem_req_wen   = MemWrite;
        mem_req_wdata = Write_data;
        mem_req_wstrb = MemWrite ? Write_strb : '0;
        Mem_Req_Ready = mem_req_ready;
        if (dreq && mem_req_ready) begin
          data_inc = 1'b1;
          if (Inst_Req_Valid) begin
            streak_d = (streak_q < STREAK_MAX) ? streak_q + 1'b1 : streak_q;
          end else begin
            streak_d = '0;
          end
          // A store is posted; a simultaneous read request is dropped.
          state_d = MemWrite ? IDLE : D_RESP;
        end else if (!dreq) begin
          state_d = IDLE;
        end
      end
      D_RESP: begin
        Read_data_Valid = mem_rdata_valid;
        Read_data       = mem_rdata_valid ? mem_rdata : '0;
        mem_rdata_ready = Read_data_Ready;
        if (mem_rdata_valid && Read_data_Ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    conflict_inc = (Inst_Req_Valid && ((state_q == D_REQ) || (state_q == D_RESP))) ||
                   (dreq && ((state_q == I_REQ) || (state_q == I_RESP)));
  end

  arb_perf_counter u_cnt_inst (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (inst_inc),
    .count_o (perf_inst_grant)
  );

  arb_perf_counter u_cnt_data (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (data_inc),
    .count_o (perf_data_grant)
  );

  arb_perf_counter u_cnt_conflict (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (conflict_inc),
    .count_o (perf_conflict)
  );

endmodule
